// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, entry type and result select for the writeback commit queue
package wb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_REG_BITS   = 7;

    // One pending register-file write: destination index plus selected result
    typedef struct packed {
        logic [WB_REG_BITS-1:0]   addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    // Pick the load result when muxD is set, otherwise the ALU result
    function automatic logic [WB_DATA_WIDTH-1:0] wb_select(
        input logic                     muxD,
        input logic [WB_DATA_WIDTH-1:0] dataD,
        input logic [WB_DATA_WIDTH-1:0] w
    );
        return muxD ? dataD : w;
    endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// rtl/wb_fwd_match.sv - youngest-first associative lookup over pending queue entries
module wb_fwd_match #(
    parameter int DEPTH      = 4,
    parameter int REG_BITS   = 7,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_BITS   = $clog2(DEPTH)
) (
    input  logic [REG_BITS-1:0]   ent_addr [DEPTH],
    input  logic [DATA_WIDTH-1:0] ent_data [DEPTH],
    input  logic [DEPTH-1:0]      valid,
    input  logic [PTR_BITS-1:0]   tail,
    input  logic [REG_BITS-1:0]   lookup,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] data
);

    logic [PTR_BITS-1:0] idx;

    // Walk backwards from the slot just before the tail so the first valid match is the youngest
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            idx = tail - PTR_BITS'(k);
            if (!hit && valid[idx] && (ent_addr[idx] == lookup)) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/wb_commit_queue.sv
// rtl/wb_commit_queue.sv - in-order writeback FIFO draining into a granted register-file port
module wb_commit_queue
    import wb_pkg::*;
#(
    // Widths must stay equal to the package defaults because storage uses wb_entry_t
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int REG_BITS   = WB_REG_BITS,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] W_dataD,
    input  logic [DATA_WIDTH-1:0] W_w,
    input  logic [REG_BITS-1:0]   W_regDst,
    input  logic                  W_MuxD,
    input  logic                  W_RF_wrd,
    output logic                  W_stall,
    output logic                  RF_we,
    output logic [REG_BITS-1:0]   RF_addr,
    output logic [DATA_WIDTH-1:0] RF_data,
    input  logic                  RF_grant,
    input  logic [REG_BITS-1:0]   fwd_addr_a,
    input  logic [REG_BITS-1:0]   fwd_addr_b,
    output logic                  fwd_hit_a,
    output logic                  fwd_hit_b,
    output logic [DATA_WIDTH-1:0] fwd_data_a,
    output logic [DATA_WIDTH-1:0] fwd_data_b,
    output logic                  wb_empty
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t             mem [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [PW:0]           count;
    logic                  full;
    logic                  empty;
    logic                  enq;
    logic                  deq;
    logic [DEPTH-1:0]      valid;
    logic [PW-1:0]         age;
    logic [REG_BITS-1:0]   ent_addr [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];

    // Full/empty come from the registered count only, so grant never reaches W_stall
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign enq      = W_RF_wrd && !full;
    assign deq      = !empty && RF_grant;

    assign W_stall  = full;
    assign wb_empty = empty;
    assign RF_we    = !empty;
    assign RF_addr  = empty ? '0 : mem[head].addr;
    assign RF_data  = empty ? '0 : mem[head].data;

    // Pointer and occupancy bookkeeping; reset drops every pending write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; occupancy alone decides what is live
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= '{addr: W_regDst, data: wb_select(W_MuxD, W_dataD, W_w)};
        end
    end

    // A slot is live when its distance from the head is below the count
    always_comb begin
        valid = '0;
        age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age      = PW'(i) - head;
            valid[i] = ({1'b0, age} < count);
            ent_addr[i] = mem[i].addr;
            ent_data[i] = mem[i].data;
        end
    end

    wb_fwd_match #(
        .DEPTH      (DEPTH),
        .REG_BITS   (REG_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fwd_a (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .valid    (valid),
        .tail     (tail),
        .lookup   (fwd_addr_a),
        .hit      (fwd_hit_a),
        .data     (fwd_data_a)
    );

    wb_fwd_match #(
        .DEPTH      (DEPTH),
        .REG_BITS   (REG_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fwd_b (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .valid    (valid),
        .tail     (tail),
        .lookup   (fwd_addr_b),
        .hit      (fwd_hit_b),
        .data     (fwd_data_b)
    );

endmodule

// File: tb/tb_wb_commit_queue.sv
// tb/tb_wb_commit_queue.sv - randomized and directed checks of wb_commit_queue against a queue model
module tb_wb_commit_queue;

    localparam int DW    = 32;
    localparam int RB    = 7;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] W_dataD, W_w;
    logic [RB-1:0] W_regDst;
    logic          W_MuxD, W_RF_wrd;
    logic          W_stall, RF_we, RF_grant;
    logic [RB-1:0] RF_addr;
    logic [DW-1:0] RF_data;
    logic [RB-1:0] fwd_addr_a, fwd_addr_b;
    logic          fwd_hit_a, fwd_hit_b;
    logic [DW-1:0] fwd_data_a, fwd_data_b;
    logic          wb_empty;

    always #5 clk = ~clk;

    wb_commit_queue #(.DATA_WIDTH(DW), .REG_BITS(RB), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .W_dataD    (W_dataD),
        .W_w        (W_w),
        .W_regDst   (W_regDst),
        .W_MuxD     (W_MuxD),
        .W_RF_wrd   (W_RF_wrd),
        .W_stall    (W_stall),
        .RF_we      (RF_we),
        .RF_addr    (RF_addr),
        .RF_data    (RF_data),
        .RF_grant   (RF_grant),
        .fwd_addr_a (fwd_addr_a),
        .fwd_addr_b (fwd_addr_b),
        .fwd_hit_a  (fwd_hit_a),
        .fwd_hit_b  (fwd_hit_b),
        .fwd_data_a (fwd_data_a),
        .fwd_data_b (fwd_data_b),
        .wb_empty   (wb_empty)
    );

    typedef struct {
        logic [RB-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t model_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Youngest pending write to the address, searched from the back of the model queue
    task automatic ref_fwd(input logic [RB-1:0] a, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (model_q[i].addr == a) begin
                h = 1'b1;
                d = model_q[i].data;
                break;
            end
        end
    endtask

    task automatic check_state();
        logic          h;
        logic [DW-1:0] d;
        int            n;
        n = model_q.size();
        check("wb_empty", 64'(wb_empty), 64'(n == 0));
        check("RF_we",    64'(RF_we),    64'(n != 0));
        check("W_stall",  64'(W_stall),  64'(n == DEPTH));
        check("RF_addr",  64'(RF_addr),  (n != 0) ? 64'(model_q[0].addr) : 64'd0);
        check("RF_data",  64'(RF_data),  (n != 0) ? 64'(model_q[0].data) : 64'd0);
        ref_fwd(fwd_addr_a, h, d);
        check("fwd_hit_a",  64'(fwd_hit_a),  64'(h));
        check("fwd_data_a", 64'(fwd_data_a), 64'(d));
        ref_fwd(fwd_addr_b, h, d);
        check("fwd_hit_b",  64'(fwd_hit_b),  64'(h));
        check("fwd_data_b", 64'(fwd_data_b), 64'(d));
    endtask

    // One clock: drive at the falling edge, check, then apply the queue rules at the rising edge
    task automatic cycle(input logic wrd, input logic muxd, input logic [DW-1:0] dd,
                         input logic [DW-1:0] ww, input logic [RB-1:0] dst, input logic grant,
                         input logic [RB-1:0] fa, input logic [RB-1:0] fb);
        logic do_enq, do_deq;
        ent_t e;
        W_RF_wrd = wrd; W_MuxD = muxd; W_dataD = dd; W_w = ww; W_regDst = dst;
        RF_grant = grant; fwd_addr_a = fa; fwd_addr_b = fb;
        #1;
        check_state();
        do_enq = wrd && (model_q.size() < DEPTH);
        do_deq = grant && (model_q.size() > 0);
        e.addr = dst;
        e.data = muxd ? dd : ww;
        @(posedge clk);
        if (do_deq) void'(model_q.pop_front());
        if (do_enq) model_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic grant);
        cycle(1'b0, 1'b0, $urandom, $urandom, 7'($urandom), grant, 7'd0, 7'd0);
    endtask

    int accepted;
    int guard;
    logic g;

    initial begin
        reset = 1'b1;
        W_RF_wrd = 0; W_MuxD = 0; W_dataD = 0; W_w = 0; W_regDst = 0;
        RF_grant = 0; fwd_addr_a = 0; fwd_addr_b = 0;
        @(negedge clk);
        #1;
        check("rst_wb_empty", 64'(wb_empty), 64'd1);
        check("rst_RF_we",    64'(RF_we),    64'd0);
        check("rst_W_stall",  64'(W_stall),  64'd0);
        check("rst_RF_addr",  64'(RF_addr),  64'd0);
        check("rst_RF_data",  64'(RF_data),  64'd0);
        check("rst_fwd_hit",  64'({fwd_hit_a, fwd_hit_b}), 64'd0);
        check("rst_fwd_data", 64'(fwd_data_a | fwd_data_b), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single write with grant held: visible next cycle, gone the cycle after
        cycle(1, 1, 32'h1234, 32'hAAAA, 7'd5, 1, 7'd0, 7'd0);
        check("single_we",   64'(RF_we),   64'd1);
        check("single_addr", 64'(RF_addr), 64'd5);
        check("single_data", 64'(RF_data), 64'h1234);
        idle(1);
        check("single_empty", 64'(wb_empty), 64'd1);

        // Fill without grant, drop a fifth request, then drain in order
        for (int i = 0; i < 4; i++) cycle(1, 0, $urandom, 32'h10 + i, 7'(i + 1), 0, 7'd2, 7'd9);
        check("fill_stall", 64'(W_stall), 64'd1);
        cycle(1, 0, 32'h0, 32'h99, 7'd9, 0, 7'd9, 7'd4);
        for (int i = 0; i < 4; i++) begin
            check("drain_addr", 64'(RF_addr), 64'(i + 1));
            check("drain_data", 64'(RF_data), 64'(32'h10 + i));
            idle(1);
            if (i == 0) check("drain_unstall", 64'(W_stall), 64'd0);
        end
        check("drain_empty", 64'(wb_empty), 64'd1);

        // Forwarding picks the younger of two writes to r7
        cycle(1, 0, 32'h0, 32'h11, 7'd7, 0, 7'd0, 7'd0);
        cycle(1, 0, 32'h0, 32'h22, 7'd7, 0, 7'd0, 7'd0);
        fwd_addr_a = 7'd7; fwd_addr_b = 7'd8;
        #1;
        check("fwd_hit_a7",  64'(fwd_hit_a),  64'd1);
        check("fwd_data_a7", 64'(fwd_data_a), 64'h22);
        check("fwd_hit_b8",  64'(fwd_hit_b),  64'd0);
        check("fwd_data_b8", 64'(fwd_data_b), 64'd0);
        idle(1);
        idle(1);

        // No valid request, arbitrary data: nothing enqueued
        for (int i = 0; i < 5; i++) begin
            idle(1'($urandom));
            check("gate_empty", 64'(wb_empty), 64'd1);
            check("gate_we",    64'(RF_we),    64'd0);
        end

        // Twelve distinct writes with toggling grant; stalled requests are held and retried
        accepted = 0;
        guard    = 0;
        g        = 1'b1;
        while (accepted < 12 && guard < 100) begin
            logic stalled;
            stalled = (model_q.size() == DEPTH);
            cycle(1, 1, 32'hC000 + accepted, 32'h0, 7'(accepted % 5), g, 7'($urandom_range(0, 4)), 7'd3);
            if (!stalled) accepted++;
            g = ~g;
            guard++;
        end
        check("wrap_accepted", 64'(accepted), 64'd12);
        for (int i = 0; i < 6; i++) idle(1);
        check("wrap_empty", 64'(wb_empty), 64'd1);

        // Asynchronous reset between edges with two entries pending
        cycle(1, 0, 32'h0, 32'h51, 7'd2, 0, 7'd0, 7'd0);
        cycle(1, 0, 32'h0, 32'h52, 7'd6, 0, 7'd0, 7'd0);
        fwd_addr_a = 7'd2; fwd_addr_b = 7'd6;
        #2;
        reset = 1'b1;
        #1;
        check("arst_we",    64'(RF_we),    64'd0);
        check("arst_empty", 64'(wb_empty), 64'd1);
        check("arst_stall", 64'(W_stall),  64'd0);
        check("arst_hit",   64'({fwd_hit_a, fwd_hit_b}), 64'd0);
        model_q.delete();
        @(negedge clk);
        reset = 1'b0;
        cycle(1, 1, 32'h77, 32'h0, 7'd3, 1, 7'd3, 7'd0);
        check("post_rst_addr", 64'(RF_addr), 64'd3);
        check("post_rst_data", 64'(RF_data), 64'h77);
        idle(1);
        check("post_rst_empty", 64'(wb_empty), 64'd1);

        // Random traffic over a small register range to exercise hits and wrap
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom,
                  7'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0),
                  7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
